fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side consumer for the team's asynchronous FIFO, living entirely in the read clock domain. On a start command it pops exactly `burst_len` words from the FIFO and re-presents them on a valid/ready stream with a last-word marker and a running XOR checksum. A 2-entry credit-controlled buffer absorbs the FIFO's one-cycle read latency, so downstream backpressure never loses data.

## Interface
- `DATA_WIDTH`, default 8: FIFO word and stream width.
- `LEN_WIDTH`, default 5: width of `burst_len`; maximum burst is 2^LEN_WIDTH−1 words.

- `r_clk`  in  1  read-domain clock; the single clock of the block.
- `r_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LEN_WIDTH  words to transfer; sampled with `start`.
- `fifo_empty`  in  1  FIFO empty flag, already synchronous to `r_clk`.
- `fifo_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_r_en` is high while `fifo_empty` is low.
- `fifo_r_en`  out  1  FIFO pop request.
- `out_data`  out  DATA_WIDTH  stream data (buffer head, registered).
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  downstream ready; a transfer occurs when `out_valid && out_ready`.
- `out_last`  out  1  high with the final word of a burst.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse at burst completion.
- `checksum`  out  DATA_WIDTH  XOR of all words transferred in the current or last burst.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on `start`=1 with `burst_len`≠0, latch the length, clear `checksum`, clear the issue and transfer counters, go to READ. On `start`=1 with `burst_len`=0, go to DONE with no reads.
- READ: `fifo_r_en` = `!fifo_empty && issued < len && (occupancy + inflight − pop) < 2`.
  - `pop` is a transfer in the same cycle.
  - `inflight` is 1 in the cycle after a pop request.
  - When `issued` reaches `len`, go to DRAIN.
- DRAIN: `fifo_r_en`=0. Once the final word transfers, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Buffer: 2-entry FIFO of DATA_WIDTH. It captures `fifo_data` in the cycle after each issued pop. Simultaneous capture and transfer is legal.
- `out_last` = `out_valid` && head is word number `len` of the burst.
- `checksum` is XOR-updated on every transfer. It holds its value in IDLE until the next accepted `start`.
- `start` while `busy`: ignored.
- `fifo_empty` asserted mid-burst: pops pause and resume when it deasserts. There is no timeout.
- `out_ready` low: at most 2 words are buffered or in flight; pops stop and no word is dropped or duplicated.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `fifo_r_en`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `done`=0, `checksum`=0, state IDLE, buffer empty.
- Reset mid-burst returns everything to reset values immediately. A word popped but not yet captured is discarded.
- `start` sampled at edge 0 gives `busy`=1 from cycle 1 and earliest `fifo_r_en` in cycle 1.
- `fifo_data` captures at the end of cycle 2. Earliest `out_valid` is cycle 3, so start-to-first-word latency is 3 cycles.
- Throughput is 1 word per cycle with `out_ready`=1 and the FIFO non-empty. A burst of N words finishes its last transfer in cycle N+2.
- `done` pulses the cycle after the last transfer, with `busy` still 1. `busy` drops the following cycle.
- `fifo_r_en` never asserts while `fifo_empty`=1 and never exceeds `len` pops per burst.

## Test plan
- FIFO preloaded with 0x01..0x10, `burst_len`=16, `out_ready`=1 → 16 consecutive transfers in cycles 3..18 in order. `out_last` with 0x10. `checksum`=0x10. `done` in cycle 19. Exactly 16 pops.
- FIFO preloaded with 0xA5, 0x5A, 0xFF, `burst_len`=3, `out_ready` toggling 1/0 every cycle → words delivered in order, none duplicated. `checksum`=0x00. `out_data` stable while stalled.
- FIFO empty at start, one word pushed every 4 cycles, `burst_len`=4 → `fifo_r_en` only in cycles with `fifo_empty`=0. 4 transfers, then `done`.
- `out_ready`=0 for 10 cycles with a full FIFO → exactly 2 pops occur, then `fifo_r_en` stays 0. Releasing `out_ready` resumes the burst with no loss.
- `burst_len`=0 → no pops, `done` one cycle after start, `checksum`=0. A second `start` pulsed while `busy` is ignored.
- Reset asserted mid-burst after 5 of 10 words → all outputs at reset values immediately. A new burst of 2 words delivers the next 2 FIFO entries correctly.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for the asynchronous FIFO: pops burst_len words and
// replays them on a valid/ready stream with a last marker and XOR checksum.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 5
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  xfer_q, xfer_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic                  inflight_q, inflight_d;

   logic                  pop;
   logic [2:0]            credit_used;
   logic [LEN_WIDTH-1:0]  issued_inc;
   logic [LEN_WIDTH-1:0]  xfer_inc;

   assign out_valid   = (count_q != 2'd0);
   assign pop         = out_valid && out_ready;
   assign out_data    = head_q;
   assign checksum    = checksum_q;
   assign busy        = (state_q != IDLE);
   assign issued_inc  = issued_q + LEN_WIDTH'(1);
   assign xfer_inc    = xfer_q + LEN_WIDTH'(1);
   // Words leave the buffer in order, so the head is word number xfer_q + 1.
   assign out_last    = out_valid && (xfer_inc == len_q);
   // Slots already committed next cycle: buffered plus in flight, minus the one leaving now.
   assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);

   // NOTE: every variable gets its default before the case, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q;
      xfer_d     = xfer_q;
      checksum_d = checksum_q;
      fifo_r_en  = 1'b0;
      done       = 1'b0;

      if (pop) begin
         xfer_d     = xfer_inc;
         checksum_d = checksum_q ^ head_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d      = burst_len;
               issued_d   = '0;
               xfer_d     = '0;
               checksum_d = '0;
               if (burst_len == '0) state_d = DONE;
               else                 state_d = READ;
            end
         end
         READ: begin
            fifo_r_en = !fifo_empty && (issued_q < len_q) && (credit_used < 3'd2);
            if (fifo_r_en) begin
               issued_d = issued_inc;
               if (issued_inc == len_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (xfer_inc == len_q)) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-slot skid buffer: head drives the stream, tail holds the overflow word.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      inflight_d = fifo_r_en;

      case ({inflight_q, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = fifo_data;
            else                 tail_d = fifo_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) head_d = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = fifo_data;
            end else begin
               head_d = fifo_data;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the buffer slots are reset too, since out_data must read 0 out of reset.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         xfer_q     <= '0;
         checksum_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         xfer_q     <= xfer_d;
         checksum_q <= checksum_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, scoreboard of popped
// words, table-driven scenarios, a mid-burst reset sequence and random bursts.
module tb_fifo_burst_reader;

   localparam int DW     = 8;
   localparam int LW     = 5;
   localparam int BUDGET = 300;

   logic          r_clk = 1'b0;
   logic          r_rst;
   logic          start;
   logic [LW-1:0] burst_len;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data  = '0;
   logic          fifo_r_en;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [DW-1:0] checksum;

   always #5 r_clk = ~r_clk;

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .r_clk      (r_clk),
      .r_rst      (r_rst),
      .start      (start),
      .burst_len  (burst_len),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: one-cycle read latency; every popped word goes to the scoreboard.
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] pend_q[$];
   logic          push_en   = 1'b0;
   logic [DW-1:0] push_word = '0;
   logic [DW-1:0] fm_word;
   int            pops       = 0;
   int            empty_pops = 0;

   always @(posedge r_clk) begin
      if (fifo_r_en) begin
         if (fifo_empty) begin
            empty_pops++;
         end else begin
            fm_word = fifo_q.pop_front();
            fifo_data <= fm_word;
            exp_q.push_back(fm_word);
            pops++;
         end
      end
      if (push_en) fifo_q.push_back(push_word);
      fifo_empty <= (fifo_q.size() == 0);
   end

   typedef struct {
      int                  len;
      int                  ready_mode;  // 0 always, 1 toggle, 2 low in cycles 1..10, 3 random
      int                  push_mode;   // 0 preload, 1 every push_period cycles, 2 random
      int                  push_period;
      int                  nwords;
      logic [15:0][DW-1:0] words;
      int                  poke;        // cycle in which a stray start is pulsed, 0 = none
      int                  exp_first;
      int                  exp_last;
      int                  exp_done;
      bit                  chk_cks;
      logic [DW-1:0]       exp_cks;
   } vec_t;

   function automatic vec_t blank();
      vec_t v;
      v.len = 0; v.ready_mode = 0; v.push_mode = 0; v.push_period = 0;
      v.nwords = 0; v.words = '0; v.poke = 0;
      v.exp_first = 0; v.exp_last = 0; v.exp_done = 0;
      v.chk_cks = 1'b0; v.exp_cks = '0;
      return v;
   endfunction

   task automatic preload(input logic [15:0][DW-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge r_clk); #1;
         push_en   = 1'b1;
         push_word = w[i];
      end
      @(posedge r_clk); #1;
      push_en = 1'b0;
   endtask

   task automatic kick(input int len);
      @(posedge r_clk); #1;
      start     = 1'b1;
      burst_len = LW'(len);
      @(posedge r_clk); #1;
      start     = 1'b0;
   endtask

   task automatic drive_cycle(input vec_t v, input int c);
      case (v.ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (c % 2 == 1);
         2:       out_ready = (c > 10);
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      push_en = 1'b0;
      if (pend_q.size() > 0) begin
         if ((v.push_mode == 1 && (c % v.push_period) == 0) ||
             (v.push_mode == 2 && $urandom_range(0, 1) == 1)) begin
            push_en   = 1'b1;
            push_word = pend_q.pop_front();
         end
      end
      start = (v.poke == c);
      if (start) burst_len = LW'(7);
   endtask

   task automatic run_burst(input vec_t v);
      int            c, nx, pops0, first_c, last_c, done_c;
      logic [DW-1:0] cks, held, w;
      bit            stalled;
      if (v.push_mode == 0) preload(v.words, v.nwords);
      else for (int i = 0; i < v.nwords; i++) pend_q.push_back(v.words[i]);
      exp_q.delete();
      pops0 = pops; nx = 0; first_c = 0; last_c = 0; done_c = 0;
      cks = '0; held = '0; stalled = 1'b0;
      kick(v.len);
      c = 1;
      forever begin
         drive_cycle(v, c);
         @(negedge r_clk);
         check("busy_in_burst", busy, 1'b1);
         if (stalled) check("stall_hold", out_data, held);
         check("last", out_last, out_valid && (nx + 1 == v.len));
         if (out_valid && out_ready) begin
            check("word_was_popped", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check("data", out_data, w);
               cks ^= w;
            end
            nx++;
            if (first_c == 0) first_c = c;
            last_c = c;
         end
         if (v.ready_mode == 2 && c == 10) begin
            check("stall_pops", pops - pops0, 2);
            check("stall_r_en", fifo_r_en, 1'b0);
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (done) begin
            done_c = c;
            break;
         end
         if (c >= BUDGET) begin
            check("burst_timeout", c, 0);
            break;
         end
         @(posedge r_clk); #1;
         c++;
      end
      check("xfer_count", nx, v.len);
      check("pop_count", pops - pops0, v.len);
      check("checksum_model", checksum, cks);
      if (v.chk_cks)        check("checksum_const", checksum, v.exp_cks);
      if (v.exp_first != 0) check("first_xfer_cycle", first_c, v.exp_first);
      if (v.exp_last != 0)  check("last_xfer_cycle", last_c, v.exp_last);
      if (v.exp_done != 0)  check("done_cycle", done_c, v.exp_done);
      @(posedge r_clk); #1;
      start   = 1'b0;
      push_en = 1'b0;
      @(negedge r_clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("checksum_hold", checksum, cks);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_fifo_r_en"}, fifo_r_en, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_last"},  out_last, 1'b0);
      check({tag, "_out_data"},  out_data, '0);
      check({tag, "_busy"},      busy, 1'b0);
      check({tag, "_done"},      done, 1'b0);
      check({tag, "_checksum"},  checksum, '0);
   endtask

   vec_t                tbl[5];
   vec_t                v;
   logic [15:0][DW-1:0] rw;
   logic [DW-1:0]       w;
   int                  c, nx;

   initial begin
      r_rst = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
      repeat (2) @(posedge r_clk);
      #1;
      check_reset_values("por");
      r_rst = 1'b1;

      // Ordered 16-word burst with a stray start mid-burst.
      tbl[0] = blank();
      tbl[0].len = 16; tbl[0].nwords = 16; tbl[0].poke = 5;
      for (int i = 0; i < 16; i++) tbl[0].words[i] = DW'(i + 1);
      tbl[0].exp_first = 3; tbl[0].exp_last = 18; tbl[0].exp_done = 19;
      tbl[0].chk_cks = 1'b1; tbl[0].exp_cks = 8'h10;
      // Ready toggling every cycle.
      tbl[1] = blank();
      tbl[1].len = 3; tbl[1].nwords = 3; tbl[1].ready_mode = 1;
      tbl[1].words[0] = 8'hA5; tbl[1].words[1] = 8'h5A; tbl[1].words[2] = 8'hFF;
      tbl[1].chk_cks = 1'b1; tbl[1].exp_cks = 8'h00;
      // Zero-length burst, start pulsed again while in DONE.
      tbl[2] = blank();
      tbl[2].len = 0; tbl[2].poke = 1; tbl[2].exp_done = 1;
      tbl[2].chk_cks = 1'b1; tbl[2].exp_cks = 8'h00;
      // Ten cycles of backpressure against a full FIFO.
      tbl[3] = blank();
      tbl[3].len = 6; tbl[3].nwords = 6; tbl[3].ready_mode = 2;
      for (int i = 0; i < 6; i++) tbl[3].words[i] = DW'(8'h31 + i);
      tbl[3].exp_first = 11; tbl[3].exp_last = 16; tbl[3].exp_done = 17;
      tbl[3].chk_cks = 1'b1; tbl[3].exp_cks = 8'h07;
      // Empty FIFO at start, one push every 4 cycles.
      tbl[4] = blank();
      tbl[4].len = 4; tbl[4].nwords = 4; tbl[4].push_mode = 1; tbl[4].push_period = 4;
      tbl[4].words[0] = 8'h11; tbl[4].words[1] = 8'h22;
      tbl[4].words[2] = 8'h33; tbl[4].words[3] = 8'h44;
      tbl[4].chk_cks = 1'b1; tbl[4].exp_cks = 8'h44;

      for (int i = 0; i < 5; i++) run_burst(tbl[i]);

      // Reset after 5 of 10 words; the next burst must see the following FIFO entries.
      rw = '0;
      for (int i = 0; i < 12; i++) rw[i] = DW'(8'h61 + i);
      preload(rw, 12);
      exp_q.delete();
      kick(10);
      out_ready = 1'b1;
      nx = 0; c = 1;
      while (nx < 5 && c < 50) begin
         @(negedge r_clk);
         if (out_valid && out_ready) begin
            check("rst_word_was_popped", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check("rst_data", out_data, w);
            end
            nx++;
         end
         if (nx < 5) begin
            @(posedge r_clk); #1;
            c++;
         end
      end
      check("rst_fifth_xfer_cycle", c, 7);
      @(posedge r_clk); #1;
      r_rst = 1'b0;
      #1;
      check_reset_values("mid_rst");
      @(posedge r_clk); #1;
      r_rst = 1'b1;
      check("rst_fifo_left", fifo_q.size(), 5);
      v = blank();
      v.len = 2; v.exp_first = 3; v.exp_last = 4; v.exp_done = 5;
      v.chk_cks = 1'b1; v.exp_cks = 8'h68 ^ 8'h69;
      run_burst(v);

      // Random lengths, random backpressure, random FIFO refill.
      for (int k = 0; k < 8; k++) begin
         v = blank();
         v.len = $urandom_range(1, 16);
         v.nwords = v.len;
         v.ready_mode = 3;
         v.push_mode = 2;
         for (int j = 0; j < v.nwords; j++) v.words[j] = DW'($urandom);
         run_burst(v);
      end

      check("pop_while_empty", empty_pops, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
